din_sel_seq: RTL and testbench

DIN_SEL_SEQ -- requirements
Module: din_sel_seq

---
 rtl/din_sel_seq.sv | 101 ++++++++++
 tb/tb_din_sel_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/din_sel_seq.sv
// din_sel_seq: epoch-based sample read sequencer; define DIN_SEL_SEQ_PINGPONG_EN for alternating read direction
module din_sel_seq #(
  parameter int DEPTH = 10,
  parameter int ADDR_W = 4,
  parameter int EPOCH_W = 8,
  parameter int INIT_CYC = 2
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic               start,
  input  logic               stop,
  input  logic               stall,
  input  logic [EPOCH_W-1:0] epochs,
  output logic               din,
  output logic [ADDR_W-1:0]  addr,
  output logic               select_initial,
  output logic               epoch_done,
  output logic               busy,
  output logic               done
);
  localparam int IC_W = $clog2(INIT_CYC + 1);
  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(DEPTH - 1);
  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;
  state_t state;
  logic [IC_W-1:0] ic;
  logic [EPOCH_W-1:0] ep, last_ep, nep;
  logic [ADDR_W-1:0] pend, pend_end;
`ifdef DIN_SEL_SEQ_PINGPONG_EN
  // next pending address; epoch_done marks the read just issued as the epoch's last, so wrap to the next epoch's start
  always_comb begin
    nep = ep + EPOCH_W'(epoch_done);
    pend = !din ? addr : epoch_done ? (ep[0] ? '0 : TOP) : (ep[0] ? addr - ADDR_W'(1) : addr + ADDR_W'(1));
    pend_end = nep[0] ? '0 : TOP;
  end
`else
  // next pending address; every epoch ascends so the wrap always returns to 0
  always_comb begin
    nep = ep + EPOCH_W'(epoch_done);
    pend = !din ? addr : epoch_done ? '0 : addr + ADDR_W'(1);
    pend_end = TOP;
  end
`endif
  // sequencer state with all outputs registered
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state <= IDLE;
      ic <= '0;
      ep <= '0;
      last_ep <= '0;
      din <= 1'b0;
      addr <= '0;
      select_initial <= 1'b0;
      epoch_done <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      din <= 1'b0;
      select_initial <= 1'b0;
      epoch_done <= 1'b0;
      done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        addr <= '0;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state <= INIT;
            ic <= '0;
            last_ep <= (epochs == '0) ? '0 : epochs - EPOCH_W'(1);
            busy <= 1'b1;
          end
          INIT: if (ic == IC_W'(INIT_CYC)) begin
            state <= RUN;
            din <= 1'b1;
            addr <= '0;
            ep <= '0;
          end else begin
            ic <= ic + IC_W'(1);
            select_initial <= 1'b1;
          end
          RUN: if (epoch_done && ep == last_ep) begin
            state <= DONE;
            addr <= '0;
            done <= 1'b1;
          end else begin
            din <= !stall;
            addr <= pend;
            ep <= nep;
            epoch_done <= !stall && pend == pend_end;
          end
          default: begin
            state <= IDLE;
            addr <= '0;
            busy <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_din_sel_seq.sv
// tb_din_sel_seq: randomized and directed bench for din_sel_seq against a read-index model
module tb_din_sel_seq;
  localparam int DEPTH = 4, ADDR_W = 3, EPOCH_W = 8, INIT_CYC = 2;
  logic clk = 1'b0;
  logic res_n;
  logic start = 1'b0, stop = 1'b0, stall = 1'b0;
  logic [EPOCH_W-1:0] epochs = '0;
  logic din, select_initial, epoch_done, busy, done;
  logic [ADDR_W-1:0] addr;
  int errs = 0, checks = 0;
  bit chk_en = 0;
  int sel_cnt, ed_cnt, done_cnt;
  int rd_q[$];
  int exp_rd[8];

  din_sel_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .EPOCH_W(EPOCH_W), .INIT_CYC(INIT_CYC)) dut (
    .clk(clk), .res_n(res_n), .start(start), .stop(stop), .stall(stall), .epochs(epochs),
    .din(din), .addr(addr), .select_initial(select_initial), .epoch_done(epoch_done),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // address of the k-th read of a run (0-based, across epochs)
  function automatic int addr_of(int k);
    int e = k / DEPTH;
    int i = k % DEPTH;
`ifdef DIN_SEL_SEQ_PINGPONG_EN
    if (e % 2 == 1) return DEPTH - 1 - i;
`endif
    return i;
  endfunction

  // model: mode 0 idle, 1 init, 2 run, 3 done; m_k counts reads completed
  int m_mode, m_ic, m_k, m_n;
  logic e_din, e_sel, e_ed, e_busy, e_done;
  int e_addr;
  always @(posedge clk or negedge res_n) begin
    if (!res_n || stop) begin
      m_mode = 0;
      {e_din, e_sel, e_ed, e_busy, e_done} = '0;
      e_addr = 0;
    end else begin
      e_sel = 0;
      e_done = 0;
      case (m_mode)
        0: if (start) begin m_mode = 1; m_ic = 0; m_n = (epochs == 0) ? 1 : int'(epochs); e_busy = 1; end
        1: if (m_ic < INIT_CYC) begin
             m_ic++; e_sel = 1;
           end else begin
             m_mode = 2; m_k = 0; e_din = 1; e_addr = addr_of(0); e_ed = 0;
           end
        2: begin
             if (e_din) m_k++;
             if (m_k == m_n * DEPTH) begin
               m_mode = 3; e_din = 0; e_ed = 0; e_addr = 0; e_done = 1;
             end else begin
               e_din = !stall; e_addr = addr_of(m_k); e_ed = e_din && (m_k % DEPTH == DEPTH - 1);
             end
           end
        default: begin m_mode = 0; e_busy = 0; e_addr = 0; end
      endcase
    end
  end

  // per-cycle comparison against the model plus observation log
  always @(negedge clk) if (chk_en) begin
    chk("din", din, e_din);
    chk("addr", addr, e_addr);
    chk("select_initial", select_initial, e_sel);
    chk("epoch_done", epoch_done, e_ed);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("din_sel_excl", din && select_initial, 0);
    if (din) rd_q.push_back(int'(addr));
    sel_cnt += int'(select_initial);
    ed_cnt += int'(epoch_done);
    done_cnt += int'(done);
  end

  task automatic clear_obs();
    rd_q.delete(); sel_cnt = 0; ed_cnt = 0; done_cnt = 0;
  endtask

  task automatic go(input int ep);
    @(negedge clk); start = 1; epochs = EPOCH_W'(ep);
    @(negedge clk); start = 0;
  endtask

  task automatic wait_idle(input int lim);
    int t = 0;
    while (busy && t < lim) begin @(negedge clk); t++; end
    chk("idle_timeout", busy, 0);
    @(negedge clk);
  endtask

  task automatic wait_read(input int a, input int lim);
    int t = 0;
    while (!(din && int'(addr) == a) && t < lim) begin @(negedge clk); t++; end
    chk("read_timeout", din && int'(addr) == a, 1);
  endtask

  task automatic chk_rd(input string n);
    chk({n, "_count"}, rd_q.size(), 8);
    for (int i = 0; i < 8 && i < rd_q.size(); i++) chk({n, "_addr"}, rd_q[i], exp_rd[i]);
  endtask

  initial begin
`ifdef DIN_SEL_SEQ_PINGPONG_EN
    exp_rd = '{0, 1, 2, 3, 3, 2, 1, 0};
`else
    exp_rd = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    res_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_din", din, 0); chk("rst_addr", addr, 0); chk("rst_sel", select_initial, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_ed", epoch_done, 0);
    res_n = 1;
    chk_en = 1;
    repeat (3) @(negedge clk);
    chk("no_autostart", busy, 0);
    // basic two-epoch run
    clear_obs(); go(2); wait_idle(100);
    chk_rd("basic"); chk("basic_sel", sel_cnt, 2); chk("basic_ed", ed_cnt, 2); chk("basic_done", done_cnt, 1);
    // stall three cycles while address 2 is pending
    clear_obs(); go(2); wait_read(1, 50);
    stall = 1;
    repeat (3) begin @(negedge clk); chk("stall_din", din, 0); chk("stall_addr", addr, 2); end
    stall = 0;
    wait_idle(100);
    chk_rd("stall"); chk("stall_done", done_cnt, 1);
    // stop in the second run cycle, then restart
    clear_obs(); go(2); wait_read(0, 50);
    @(negedge clk); stop = 1;
    @(negedge clk); stop = 0;
    chk("stop_busy", busy, 0); chk("stop_din", din, 0); chk("stop_done", done, 0);
    repeat (3) @(negedge clk);
    chk("stop_reads", rd_q.size(), 2); chk("stop_nodone", done_cnt, 0);
    clear_obs(); go(2); wait_idle(100);
    chk_rd("restart"); chk("restart_done", done_cnt, 1);
    // asynchronous reset between edges
    go(2); wait_read(0, 50);
    @(negedge clk); #2 res_n = 0; #1;
    chk("arst_din", din, 0); chk("arst_addr", addr, 0); chk("arst_busy", busy, 0);
    chk("arst_ed", epoch_done, 0); chk("arst_sel", select_initial, 0); chk("arst_done", done, 0);
    @(negedge clk); res_n = 1;
    repeat (4) @(negedge clk);
    chk("arst_idle", busy, 0);
    // epochs=0 runs one epoch; start while busy is ignored
    clear_obs(); go(0);
    repeat (3) @(negedge clk);
    start = 1; epochs = 3; @(negedge clk); start = 0;
    wait_idle(100);
    chk("ep0_reads", rd_q.size(), 4); chk("ep0_done", done_cnt, 1); chk("ep0_ed", ed_cnt, 1);
    // randomized traffic against the model
    repeat (500) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 40) == 0);
      stall = ($urandom_range(0, 3) == 0);
      epochs = EPOCH_W'($urandom_range(0, 3));
    end
    @(negedge clk); start = 0; stop = 0; stall = 0;
    wait_idle(200);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
